// File: rtl/fpu_normalize_round_seq_pkg.sv
// rtl/fpu_normalize_round_seq_pkg.sv - shared constants, state and result types for the normalize/round stage
package FPU_192_Package;
   localparam int NORMALIZE_MANTISSA_LENGTH = 27;
   localparam int EXP_BIAS                  = 127;
   localparam int EXP_MAX                   = 255;
   localparam int HIDDEN_IDX                = 26;
   localparam int L_IDX                     = 3;
   localparam int G_IDX                     = 2;
   localparam int R_IDX                     = 1;
   localparam int S_IDX                     = 0;

   typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} norm_state_e;

   typedef struct packed {
      logic        sign;
      logic [7:0]  exp;
      logic [22:0] frac;
   } fp32_t;
endpackage

// File: rtl/fpu_normalize_round_seq_if.sv
// rtl/fpu_normalize_round_seq_if.sv - input/output handshake bundle for the normalize/round stage
interface fpu_normalize_round_seq_if
   import FPU_192_Package::*;
#(
   parameter int MAN_W = NORMALIZE_MANTISSA_LENGTH,
   parameter int EXP_W = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [MAN_W-1:0] man_in;
   logic             cout_in;
   logic             sign_in;
   logic [EXP_W-1:0] exp_in;
   logic             out_valid;
   logic             out_ready;
   logic [31:0]      result;
   logic             flag_ovf;
   logic             flag_unf;
   logic             flag_zero;

   modport master (
      output in_valid, man_in, cout_in, sign_in, exp_in, out_ready,
      input  in_ready, out_valid, result, flag_ovf, flag_unf, flag_zero
   );

   modport slave (
      input  in_valid, man_in, cout_in, sign_in, exp_in, out_ready,
      output in_ready, out_valid, result, flag_ovf, flag_unf, flag_zero
   );
endinterface

// File: rtl/fpu_normalize_round_seq_rounder.sv
// rtl/fpu_normalize_round_seq_rounder.sv - combinational round-to-nearest-even incrementer (module fpu_rne_rounder)
module fpu_rne_rounder (
   input  logic [23:0] frac24,
   input  logic        g,
   input  logic        r,
   input  logic        s,
   output logic [22:0] frac,
   output logic        hidden,
   output logic        carry,
   output logic        inexact
);
   logic        inc;
   logic [24:0] sum;

   assign inc     = g & (r | s | frac24[0]);
   assign sum     = {1'b0, frac24} + 25'(inc);
   assign carry   = sum[24];
   // A carry out leaves 1.000..0, so the renormalized fraction is the shifted sum.
   assign hidden  = sum[24] | sum[23];
   assign frac    = carry ? sum[23:1] : sum[22:0];
   assign inexact = g | r | s;
endmodule

// File: rtl/fpu_normalize_round_seq.sv
// rtl/fpu_normalize_round_seq.sv - sequential normalize, RNE round and IEEE-754 single pack
// Optional gradual underflow via FPU_DENORM_EN; undefined means flush-to-zero.
module fpu_normalize_round_seq
   import FPU_192_Package::*;
#(
   parameter int MAN_W = NORMALIZE_MANTISSA_LENGTH,
   parameter int EXP_W = 8
) (
   input logic                       clk,
   input logic                       rst,
   fpu_normalize_round_seq_if.slave  bus
);
   norm_state_e         state, state_n;
   logic [MAN_W-1:0]    man_r, man_n;
   logic signed [9:0]   exp_r, exp_n, exp_rnd;
   logic                sign_r, sign_n;
   logic                denorm_r, denorm_n;
   fp32_t               result_r, result_n;
   logic                ovf_r, ovf_n, unf_r, unf_n, zero_r, zero_n;
   logic                out_valid_r, out_valid_n;
   logic [22:0]         rnd_frac;
   logic                rnd_hidden, rnd_carry, rnd_inexact;

   fpu_rne_rounder u_rounder (
      .frac24  (man_r[HIDDEN_IDX:L_IDX]),
      .g       (man_r[G_IDX]),
      .r       (man_r[R_IDX]),
      .s       (man_r[S_IDX]),
      .frac    (rnd_frac),
      .hidden  (rnd_hidden),
      .carry   (rnd_carry),
      .inexact (rnd_inexact)
   );

   assign bus.in_ready  = (state == IDLE);
   assign bus.out_valid = out_valid_r;
   assign bus.result    = result_r;
   assign bus.flag_ovf  = ovf_r;
   assign bus.flag_unf  = unf_r;
   assign bus.flag_zero = zero_r;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         man_r       <= '0;
         exp_r       <= '0;
         sign_r      <= 1'b0;
         denorm_r    <= 1'b0;
         result_r    <= '0;
         ovf_r       <= 1'b0;
         unf_r       <= 1'b0;
         zero_r      <= 1'b0;
         out_valid_r <= 1'b0;
      end else begin
         man_r       <= man_n;
         exp_r       <= exp_n;
         sign_r      <= sign_n;
         denorm_r    <= denorm_n;
         result_r    <= result_n;
         ovf_r       <= ovf_n;
         unf_r       <= unf_n;
         zero_r      <= zero_n;
         out_valid_r <= out_valid_n;
      end
   end

   always_comb begin
      state_n     = state;
      man_n       = man_r;
      exp_n       = exp_r;
      sign_n      = sign_r;
      denorm_n    = denorm_r;
      result_n    = result_r;
      ovf_n       = ovf_r;
      unf_n       = unf_r;
      zero_n      = zero_r;
      out_valid_n = out_valid_r;
      exp_rnd     = exp_r + 10'(rnd_carry);

      case (state)
         IDLE: begin
            if (bus.in_valid) begin
               sign_n   = bus.sign_in;
               denorm_n = 1'b0;
               exp_n    = 10'(bus.exp_in);
               if (bus.cout_in) begin
                  man_n   = {1'b1, bus.man_in[MAN_W-1:2], bus.man_in[1] | bus.man_in[0]};
                  exp_n   = 10'(bus.exp_in) + 10'd1;
                  state_n = ROUND;
               end else if (bus.man_in == '0) begin
                  // Exact cancellation rounds to +0 under RNE regardless of operand signs.
                  result_n    = '0;
                  ovf_n       = 1'b0;
                  unf_n       = 1'b0;
                  zero_n      = 1'b1;
                  out_valid_n = 1'b1;
                  state_n     = DONE;
               end else begin
                  man_n   = bus.man_in;
                  state_n = bus.man_in[HIDDEN_IDX] ? ROUND : NORM;
               end
            end
         end

         NORM: begin
            if (man_r[HIDDEN_IDX]) begin
               state_n = ROUND;
            end else if (exp_r > 10'sd1) begin
               // Jump straight to ROUND when this shift brings the leading one into place.
               man_n = man_r << 1;
               exp_n = exp_r - 10'sd1;
               if (man_r[HIDDEN_IDX-1]) state_n = ROUND;
            end else begin
`ifdef FPU_DENORM_EN
               denorm_n = 1'b1;
               state_n  = ROUND;
`else
               result_n      = '0;
               result_n.sign = sign_r;
               ovf_n         = 1'b0;
               unf_n         = 1'b1;
               zero_n        = 1'b1;
               out_valid_n   = 1'b1;
               state_n       = DONE;
`endif
            end
         end

         ROUND: begin
            result_n      = '0;
            result_n.sign = sign_r;
            ovf_n         = 1'b0;
            unf_n         = 1'b0;
            zero_n        = 1'b0;
            if (denorm_r) begin
               // Rounding a denormal up into the hidden bit yields the smallest normal (exp field 1).
               result_n.exp  = {7'b0, rnd_hidden};
               result_n.frac = rnd_frac;
               unf_n         = rnd_inexact;
               zero_n        = ~rnd_hidden & (rnd_frac == '0);
            end else if (exp_rnd >= $signed(10'(EXP_MAX))) begin
               result_n.exp = 8'hFF;
               ovf_n        = 1'b1;
            end else begin
               result_n.exp  = exp_rnd[7:0];
               result_n.frac = rnd_frac;
            end
            out_valid_n = 1'b1;
            state_n     = DONE;
         end

         DONE: begin
            if (bus.out_ready) begin
               out_valid_n = 1'b0;
               state_n     = IDLE;
            end
         end

         default: state_n = IDLE;
      endcase
   end
endmodule

// File: tb/tb_fpu_normalize_round_seq.sv
// tb/tb_fpu_normalize_round_seq.sv - directed self-checking bench for fpu_normalize_round_seq
module tb_fpu_normalize_round_seq;
   logic clk;
   logic rst;
   int   checks;
   int   failures;
   int   lat;

   fpu_normalize_round_seq_if bus ();

   fpu_normalize_round_seq dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic start_op(input logic [26:0] man, input logic cout, input logic sign,
                           input logic [7:0] exp);
      @(negedge clk);
      bus.man_in   = man;
      bus.cout_in  = cout;
      bus.sign_in  = sign;
      bus.exp_in   = exp;
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_valid(output int cycles);
      cycles = 0;
      do begin
         @(negedge clk);
         cycles++;
      end while (!bus.out_valid && cycles < 60);
   endtask

   task automatic handshake(input string tag);
      @(negedge clk);
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      @(negedge clk);
      chk({tag, "_valid_clr"}, 32'(bus.out_valid), 32'd0);
      chk({tag, "_ready_idle"}, 32'(bus.in_ready), 32'd1);
   endtask

   task automatic run_op(input string tag, input logic [26:0] man, input logic cout,
                         input logic sign, input logic [7:0] exp, input logic [31:0] res,
                         input logic ovf, input logic unf, input logic zero, input int exp_lat);
      int cyc;
      start_op(man, cout, sign, exp);
      wait_valid(cyc);
      chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
      if (exp_lat >= 0) chk({tag, "_lat"}, 32'(cyc), 32'(exp_lat));
      chk({tag, "_res"}, bus.result, res);
      chk({tag, "_ovf"}, 32'(bus.flag_ovf), 32'(ovf));
      chk({tag, "_unf"}, 32'(bus.flag_unf), 32'(unf));
      chk({tag, "_zero"}, 32'(bus.flag_zero), 32'(zero));
      handshake(tag);
   endtask

   initial begin
      checks        = 0;
      failures      = 0;
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.man_in    = '0;
      bus.cout_in   = 1'b0;
      bus.sign_in   = 1'b0;
      bus.exp_in    = '0;
      bus.out_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_ready", 32'(bus.in_ready), 32'd1);
      chk("rst_result", bus.result, 32'h0);
      chk("rst_flags", {29'd0, bus.flag_ovf, bus.flag_unf, bus.flag_zero}, 32'd0);
      rst = 1'b0;

      run_op("one_plus_one", 27'h0000000, 1'b1, 1'b0, 8'd127, 32'h40000000, 0, 0, 0, 2);
      run_op("cancel_zero",  27'h0000000, 1'b0, 1'b1, 8'd100, 32'h00000000, 0, 0, 1, 1);
      run_op("shift23",      27'h0000008, 1'b0, 1'b0, 8'd127, 32'h34000000, 0, 0, 0, 25);
      run_op("rne_tie_even", 27'h4000004, 1'b0, 1'b0, 8'd127, 32'h3F800000, 0, 0, 0, 2);
      run_op("rne_tie_up",   27'h400000C, 1'b0, 1'b0, 8'd127, 32'h3F800002, 0, 0, 0, 2);
      run_op("rne_carry",    27'h7FFFFFC, 1'b0, 1'b0, 8'd127, 32'h40000000, 0, 0, 0, 2);
      run_op("cout_grs",     27'h000000C, 1'b1, 1'b0, 8'd127, 32'h40000001, 0, 0, 0, 2);
      run_op("cout_tie",     27'h0000008, 1'b1, 1'b0, 8'd127, 32'h40000000, 0, 0, 0, 2);
      run_op("cout_sticky",  27'h0000009, 1'b1, 1'b0, 8'd127, 32'h40000001, 0, 0, 0, 2);
      run_op("neg_sign",     27'h4000000, 1'b0, 1'b1, 8'd130, 32'hC1000000, 0, 0, 0, 2);
      run_op("max_normal",   27'h4000000, 1'b0, 1'b0, 8'd254, 32'h7F000000, 0, 0, 0, 2);
      run_op("overflow",     27'h7FFFFFF, 1'b1, 1'b0, 8'd254, 32'h7F800000, 1, 0, 0, 2);
`ifdef FPU_DENORM_EN
      run_op("denormal",     27'h0000008, 1'b0, 1'b0, 8'd3,   32'h00000004, 0, 0, 0, -1);
`else
      run_op("flush_zero",   27'h0000008, 1'b0, 1'b0, 8'd3,   32'h00000000, 0, 1, 1, -1);
`endif

      // Output stall with a competing input request that must not be captured.
      start_op(27'h400000C, 1'b0, 1'b0, 8'd127);
      wait_valid(lat);
      chk("stall_valid", 32'(bus.out_valid), 32'd1);
      for (int i = 0; i < 5; i++) begin
         bus.man_in   = 27'h7FFFFFF;
         bus.cout_in  = 1'b1;
         bus.exp_in   = 8'd254;
         bus.in_valid = 1'b1;
         @(negedge clk);
         chk("stall_result", bus.result, 32'h3F800002);
         chk("stall_ovf", 32'(bus.flag_ovf), 32'd0);
         chk("stall_inready", 32'(bus.in_ready), 32'd0);
         chk("stall_held", 32'(bus.out_valid), 32'd1);
      end
      bus.in_valid = 1'b0;
      handshake("stall");
      @(negedge clk);
      chk("stall_no_capture", 32'(bus.out_valid), 32'd0);

      // Asynchronous reset while normalizing.
      start_op(27'h0000008, 1'b0, 1'b0, 8'd127);
      repeat (5) @(negedge clk);
      chk("norm_busy", 32'(bus.in_ready), 32'd0);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_valid", 32'(bus.out_valid), 32'd0);
      chk("arst_ready", 32'(bus.in_ready), 32'd1);
      chk("arst_result", bus.result, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      run_op("post_rst", 27'h400000C, 1'b0, 1'b0, 8'd127, 32'h3F800002, 0, 0, 0, 2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
